fsm_stream_sched: RTL and testbench

- Sequences the serial-input protocol FSM: accepts parallel words over a valid/ready handshake and replays them MSB-first as one bit per step on the FSM's serial input.
- Gates FSM stepping with a bit-valid strobe.
- Collects the FSM's event codes (x) and output flag (y) into per-packet statistics.
- Sits between the host/command interface and the protocol FSM.

---
 rtl/fsm_stream_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_fsm_stream_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stream_sched.sv
// fsm_stream_sched
// Feeds the serial-input protocol FSM. Parallel words arrive over a
// valid/ready handshake and are replayed MSB-first, one bit per step, with
// bit_vld acting as the FSM step enable. The FSM's event codes and output
// flag are folded into per-packet statistics.
//
// Optional build macro: FSM_STREAM_PARITY_EN
//   When defined, each word is followed by one extra step carrying its
//   even-parity bit (XOR of all word bits), so a word takes DW+1 steps.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   in_valid   word available
//   in_ready   word accepted when in_valid & in_ready
//   in_data    word to serialize, MSB first
//   in_last    word is the last of its packet
//   abort_i    synchronous abort of the current packet
//   bit_o      serial bit to the FSM input
//   bit_vld    FSM step enable, bit_o valid
//   evt_i      FSM event code (0 none, 1, 2)
//   flag_i     FSM output flag
//   busy       packet in progress
//   done_o     one-cycle pulse at packet end
//   evt1_cnt   saturating count of evt_i==1 cycles in the packet
//   evt2_cnt   saturating count of evt_i==2 cycles in the packet
//   flag_seen  sticky: flag_i seen high during the packet
module fsm_stream_sched #(
    parameter int DW   = 8,
    parameter int CNTW = 8,
    parameter int GAP  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    input  logic            abort_i,
    output logic            bit_o,
    output logic            bit_vld,
    input  logic [7:0]      evt_i,
    input  logic            flag_i,
    output logic            busy,
    output logic            done_o,
    output logic [CNTW-1:0] evt1_cnt,
    output logic [CNTW-1:0] evt2_cnt,
    output logic            flag_seen
);

    localparam int BW = $clog2(DW);
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BIT_INIT = BW'(DW - 1);
    localparam logic [GW-1:0] GAP_INIT = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   shreg;
    logic            last_q;
    logic [BW-1:0]   bitcnt;
    logic [GW-1:0]   gapcnt;
    logic            accept;
    logic            word_end;

`ifdef FSM_STREAM_PARITY_EN
    logic            par_q;
    logic            par_phase;

    // The parity step is the final step of a word, so hand-off decisions
    // (next word, last, gap) are taken there instead of on bit 0.
    assign word_end = (state == ST_SHIFT) && par_phase;
`else
    assign word_end = (state == ST_SHIFT) && (bitcnt == '0);
`endif

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Abort overrides everything, including an accept or
    // the final step of a word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (word_end) begin
                    if (last_q) begin
                        state_nxt = ST_DONE;
                    end else if (GAP > 0) begin
                        state_nxt = ST_GAP;
                    end else if (accept) begin
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gapcnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end
    end

    // Output decode. With no gap, in_ready is also offered on the final step
    // of a non-last word so the next word follows without a bubble. in_ready
    // is gated by rst so nothing looks acceptable while reset is held.
    always_comb begin
        in_ready = 1'b0;
        bit_vld  = 1'b0;
        bit_o    = 1'b0;
        done_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = rst && !abort_i;
            end
            ST_SHIFT: begin
                bit_vld = 1'b1;
`ifdef FSM_STREAM_PARITY_EN
                bit_o = par_phase ? par_q : shreg[DW-1];
`else
                bit_o = shreg[DW-1];
`endif
                if (word_end && !last_q && (GAP == 0)) begin
                    in_ready = rst && !abort_i;
                end
            end
            ST_DONE: begin
                done_o = !abort_i;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Word datapath: load on accept, shift while stepping, gap countdown and
    // the packet-open flag (busy) which survives IDLE between words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg  <= '0;
            last_q <= 1'b0;
            bitcnt <= '0;
            gapcnt <= '0;
            busy   <= 1'b0;
        end else begin
            if (accept) begin
                shreg  <= in_data;
                last_q <= in_last;
                bitcnt <= BIT_INIT;
                busy   <= 1'b1;
            end else if (state == ST_SHIFT) begin
                shreg <= {shreg[DW-2:0], 1'b0};
                if (bitcnt != '0) begin
                    bitcnt <= bitcnt - BW'(1);
                end
            end
            if ((state == ST_SHIFT) && (state_nxt == ST_GAP)) begin
                gapcnt <= GAP_INIT;
            end else if ((state == ST_GAP) && (gapcnt != '0)) begin
                gapcnt <= gapcnt - GW'(1);
            end
            if (abort_i || (state == ST_DONE)) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef FSM_STREAM_PARITY_EN
    // Parity of the accepted word, and a flag marking the extra step that
    // follows bit 0. The flag is recomputed every cycle so it can never
    // linger into a later word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q     <= 1'b0;
            par_phase <= 1'b0;
        end else begin
            if (accept) begin
                par_q <= ^in_data;
            end
            par_phase <= (state == ST_SHIFT) && (bitcnt == '0) && !par_phase && !abort_i;
        end
    end
`endif

    // Packet statistics. Only the first accept of a packet (busy low) clears
    // them; accepts of later words, done and abort leave them untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt1_cnt  <= '0;
            evt2_cnt  <= '0;
            flag_seen <= 1'b0;
        end else if (accept && !busy) begin
            evt1_cnt  <= '0;
            evt2_cnt  <= '0;
            flag_seen <= 1'b0;
        end else if (busy) begin
            if ((evt_i == 8'd1) && (evt1_cnt != '1)) begin
                evt1_cnt <= evt1_cnt + CNTW'(1);
            end
            if ((evt_i == 8'd2) && (evt2_cnt != '1)) begin
                evt2_cnt <= evt2_cnt + CNTW'(1);
            end
            if (flag_i) begin
                flag_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_stream_sched.sv
// tb_fsm_stream_sched
// Directed bench for fsm_stream_sched. Instance dut runs with GAP=0,
// instance gdut with GAP=3; both share clock and reset. Inputs change one
// time unit after a rising edge, outputs are checked one unit later.
module tb_fsm_stream_sched;

`ifdef FSM_STREAM_PARITY_EN
    localparam int STEPS = 9;
`else
    localparam int STEPS = 8;
`endif

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       abort_i;
    logic       bit_o;
    logic       bit_vld;
    logic [7:0] evt_i;
    logic       flag_i;
    logic       busy;
    logic       done_o;
    logic [7:0] evt1_cnt;
    logic [7:0] evt2_cnt;
    logic       flag_seen;

    logic       g_in_valid;
    logic       g_in_ready;
    logic [7:0] g_in_data;
    logic       g_in_last;
    logic       g_abort_i;
    logic       g_bit_o;
    logic       g_bit_vld;
    logic [7:0] g_evt_i;
    logic       g_flag_i;
    logic       g_busy;
    logic       g_done_o;
    logic [7:0] g_evt1_cnt;
    logic [7:0] g_evt2_cnt;
    logic       g_flag_seen;

    int tests_run;
    int tests_failed;

    fsm_stream_sched #(.DW(8), .CNTW(8), .GAP(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .abort_i   (abort_i),
        .bit_o     (bit_o),
        .bit_vld   (bit_vld),
        .evt_i     (evt_i),
        .flag_i    (flag_i),
        .busy      (busy),
        .done_o    (done_o),
        .evt1_cnt  (evt1_cnt),
        .evt2_cnt  (evt2_cnt),
        .flag_seen (flag_seen)
    );

    fsm_stream_sched #(.DW(8), .CNTW(8), .GAP(3)) gdut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (g_in_valid),
        .in_ready  (g_in_ready),
        .in_data   (g_in_data),
        .in_last   (g_in_last),
        .abort_i   (g_abort_i),
        .bit_o     (g_bit_o),
        .bit_vld   (g_bit_vld),
        .evt_i     (g_evt_i),
        .flag_i    (g_flag_i),
        .busy      (g_busy),
        .done_o    (g_done_o),
        .evt1_cnt  (g_evt1_cnt),
        .evt2_cnt  (g_evt2_cnt),
        .flag_seen (g_flag_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial value of step j of word w (parity step after bit 0).
    function automatic logic exp_bit(input logic [7:0] w, input int j);
        if (j < 8) begin
            return w[7 - j];
        end
        return ^w;
    endfunction

    // Sends a packet of one or two words on the GAP=0 instance, keeping
    // in_valid high across the word boundary, and checks every step.
    task automatic applyStimulus(input string tag, input int n, input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] w;
        in_valid = 1'b1;
        in_data  = w0;
        in_last  = (n == 1);
        #1 checkOutput({tag, ".ready_idle"}, in_ready, 1);
        tick();
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int j = 0; j < STEPS; j++) begin
                if (j == 0) begin
                    in_valid = 1'b0;
                end
                if ((j == STEPS - 1) && (k < n - 1)) begin
                    in_valid = 1'b1;
                    in_data  = w1;
                    in_last  = 1'b1;
                end
                #1;
                checkOutput($sformatf("%s.w%0d.vld%0d", tag, k, j), bit_vld, 1);
                checkOutput($sformatf("%s.w%0d.bit%0d", tag, k, j), bit_o, exp_bit(w, j));
                checkOutput($sformatf("%s.w%0d.busy%0d", tag, k, j), busy, 1);
                checkOutput($sformatf("%s.w%0d.done%0d", tag, k, j), done_o, 0);
                checkOutput($sformatf("%s.w%0d.rdy%0d", tag, k, j), in_ready,
                            ((j == STEPS - 1) && (k < n - 1)) ? 1 : 0);
                tick();
            end
        end
        #1;
        checkOutput({tag, ".done"}, done_o, 1);
        checkOutput({tag, ".done_vld"}, bit_vld, 0);
        checkOutput({tag, ".done_busy"}, busy, 1);
        tick();
        #1;
        checkOutput({tag, ".after_done"}, done_o, 0);
        checkOutput({tag, ".after_busy"}, busy, 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h00;
        in_last    = 1'b0;
        abort_i    = 1'b0;
        evt_i      = 8'd0;
        flag_i     = 1'b0;
        g_in_valid = 1'b0;
        g_in_data  = 8'h00;
        g_in_last  = 1'b0;
        g_abort_i  = 1'b0;
        g_evt_i    = 8'd0;
        g_flag_i   = 1'b0;

        // Reset values, with in_valid high to show in_ready stays low.
        #3;
        checkOutput("rst.in_ready", in_ready, 0);
        checkOutput("rst.bit_o", bit_o, 0);
        checkOutput("rst.bit_vld", bit_vld, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done_o, 0);
        checkOutput("rst.evt1", evt1_cnt, 0);
        checkOutput("rst.evt2", evt2_cnt, 0);
        checkOutput("rst.flag", flag_seen, 0);
        checkOutput("rst.g_in_ready", g_in_ready, 0);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();

        // Single word, then back-to-back pair, then a word with odd parity.
        applyStimulus("single", 1, 8'hA5, 8'h00);
        applyStimulus("b2b", 2, 8'hF0, 8'h0F);
        applyStimulus("p07", 1, 8'h07, 8'h00);

        // GAP=3 instance: two-word packet with events during the first word.
        g_in_valid = 1'b1;
        g_in_data  = 8'hAA;
        g_in_last  = 1'b0;
        #1 checkOutput("gap.ready0", g_in_ready, 1);
        tick();
        g_in_valid = 1'b0;
        g_evt_i    = 8'd1;
        for (int j = 0; j < STEPS; j++) begin
            #1;
            checkOutput($sformatf("gap.w0.bit%0d", j), g_bit_o, exp_bit(8'hAA, j));
            checkOutput($sformatf("gap.w0.vld%0d", j), g_bit_vld, 1);
            checkOutput($sformatf("gap.w0.rdy%0d", j), g_in_ready, 0);
            tick();
        end
        g_evt_i = 8'd0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checkOutput($sformatf("gap.gvld%0d", j), g_bit_vld, 0);
            checkOutput($sformatf("gap.grdy%0d", j), g_in_ready, 0);
            checkOutput($sformatf("gap.gbusy%0d", j), g_busy, 1);
            tick();
        end
        g_in_valid = 1'b1;
        g_in_data  = 8'h55;
        g_in_last  = 1'b1;
        #1;
        checkOutput("gap.idle_rdy", g_in_ready, 1);
        checkOutput("gap.idle_vld", g_bit_vld, 0);
        checkOutput("gap.idle_busy", g_busy, 1);
        tick();
        g_in_valid = 1'b0;
        #1 checkOutput("gap.keep_evt1", g_evt1_cnt, STEPS);
        for (int j = 0; j < STEPS; j++) begin
            #1;
            checkOutput($sformatf("gap.w1.bit%0d", j), g_bit_o, exp_bit(8'h55, j));
            checkOutput($sformatf("gap.w1.vld%0d", j), g_bit_vld, 1);
            tick();
        end
        #1 checkOutput("gap.done", g_done_o, 1);
        tick();
        #1;
        checkOutput("gap.after_busy", g_busy, 0);
        checkOutput("gap.final_evt1", g_evt1_cnt, STEPS);

        // Saturation of evt1, evt2 count, flag capture across an open packet.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_last  = 1'b0;
        #1 checkOutput("sat.ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        evt_i    = 8'd1;
        repeat (300) tick();
        evt_i = 8'd2;
        repeat (5) tick();
        evt_i = 8'd3;
        repeat (2) tick();
        evt_i  = 8'd0;
        flag_i = 1'b1;
        tick();
        flag_i = 1'b0;
        #1;
        checkOutput("sat.evt1", evt1_cnt, 255);
        checkOutput("sat.evt2", evt2_cnt, 5);
        checkOutput("sat.flag", flag_seen, 1);
        checkOutput("sat.open_busy", busy, 1);
        checkOutput("sat.open_vld", bit_vld, 0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b1;
        #1 checkOutput("sat.ready_last", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1 checkOutput("sat.no_clear", evt1_cnt, 255);
        repeat (STEPS) tick();
        #1 checkOutput("sat.done", done_o, 1);
        tick();
        #1;
        checkOutput("sat.busy_end", busy, 0);
        checkOutput("sat.hold_evt1", evt1_cnt, 255);
        checkOutput("sat.hold_evt2", evt2_cnt, 5);
        checkOutput("sat.hold_flag", flag_seen, 1);

        // Abort at bit 3 with a competing in_valid.
        in_valid = 1'b1;
        in_data  = 8'h96;
        in_last  = 1'b1;
        #1 checkOutput("abt.ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        evt_i    = 8'd2;
        #1;
        checkOutput("abt.clr_evt1", evt1_cnt, 0);
        checkOutput("abt.clr_evt2", evt2_cnt, 0);
        checkOutput("abt.clr_flag", flag_seen, 0);
        tick();
        tick();
        evt_i = 8'd0;
        tick();
        tick();
        abort_i  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b0;
        #1;
        checkOutput("abt.bit3", bit_o, 0);
        checkOutput("abt.ready_blk", in_ready, 0);
        tick();
        abort_i  = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("abt.vld", bit_vld, 0);
        checkOutput("abt.busy", busy, 0);
        checkOutput("abt.idle_rdy", in_ready, 1);
        checkOutput("abt.keep_evt2", evt2_cnt, 2);
        for (int j = 0; j < STEPS + 2; j++) begin
            tick();
            #1;
            checkOutput($sformatf("abt.nodone%0d", j), done_o, 0);
            checkOutput($sformatf("abt.novld%0d", j), bit_vld, 0);
        end

        // Asynchronous reset in the middle of a word.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        evt_i    = 8'd1;
        repeat (3) tick();
        #1 checkOutput("ar.pre_vld", bit_vld, 1);
        rst = 1'b0;
        #1;
        checkOutput("ar.vld", bit_vld, 0);
        checkOutput("ar.bit", bit_o, 0);
        checkOutput("ar.busy", busy, 0);
        checkOutput("ar.ready", in_ready, 0);
        checkOutput("ar.evt1", evt1_cnt, 0);
        evt_i = 8'd0;
        tick();
        rst = 1'b1;
        for (int j = 0; j < STEPS + 2; j++) begin
            tick();
            #1 checkOutput($sformatf("ar.nodone%0d", j), done_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
